bcd_to_binary: RTL

//   Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3).

---
 rtl/bcd_to_binary.sv | 114 +++++++++++
 1 files changed

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional invalid-digit detection is enabled by defining BCD_ERR_CHECK_EN.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   bcd_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [BIN_W-1:0]      bin_o,
  output logic                  err_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + BIN_W;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [SrW-1:0]    shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              bad_q, bad_d;
  logic              bad_in;
  logic [SrW-1:0]    adjusted;
  logic [3:0]        nibble;

`ifdef BCD_ERR_CHECK_EN
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end
`else
  assign bad_in = 1'b0;
`endif

  // Shift right, then pull every BCD nibble that reached >= 8 back down by 3.
  always_comb begin
    adjusted = shreg_q >> 1;
    nibble   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nibble = adjusted[BIN_W + 4*i +: 4];
      if (nibble >= 4'd8) adjusted[BIN_W + 4*i +: 4] = nibble - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    bad_d   = bad_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          shreg_d = {bcd_i, {BIN_W{1'b0}}};
          cnt_d   = '0;
          bad_d   = bad_in;
          err_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bad_q) begin
          bin_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          shreg_d = adjusted;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(BIN_W - 1)) begin
            bin_d   = adjusted[BIN_W-1:0];
            err_d   = 1'b0;
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign done_o  = (state_q == StDone);
  assign bin_o   = bin_q;
  assign err_o   = err_q;

endmodule
